uart_frame_rx: RTL
==================

// Module: uart_frame_rx
// PURPOSE
//  Frame deframer downstream of the uart RX FIFO. Pops bytes via the uart toggle-read handshake
//  and parses SYNC|LEN|PAYLOAD|CHK frames. Validated payloads go into an internal frame buffer
//  that the consumer reads by address and releases with an ack. Back-pressure is applied by not
//  popping the uart FIFO while a frame is held.
// PARAMETERS
//  MAX_LEN         16     max payload bytes; buffer depth; power of 2, >=2
//  TIMEOUT_CYCLES  65535  max clk cycles between bytes inside a frame; 0 disables timeout
//  SYNC_BYTE       8'hA5  frame start marker
// PORTS
//  clk            in   1                  system clock
//  rst_n          in   1                  async active-low reset
//  uart_rx_ready  in   1                  uart RX FIFO non-empty
//  uart_rx_byte   in   8                  uart RX data
//  uart_rx_read   out  1                  toggle: each edge pops one uart RX byte
//  frame_valid    out  1                  held frame available in buffer
//  frame_len      out  8                  payload length of held frame (1..MAX_LEN)
//  frame_rd_addr  in   $clog2(MAX_LEN)    buffer read address
//  frame_rd_data  out  8                  buffer data, registered, 1-cycle latency
//  frame_ack      in   1                  1-cycle pulse: release held frame
//  err_chk        out  1                  1-cycle pulse: checksum mismatch
//  err_len        out  1                  1-cycle pulse: LEN==0 or LEN>MAX_LEN
//  err_timeout    out  1                  1-cycle pulse: inter-byte timeout inside a frame
//  frame_count    out  16                 count of good frames, wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0 (uart_rx_read=0, frame_len=0, frame_rd_data=0). Parser->HUNT, fetch->F_IDLE.
//   The uart shares rst_n, so the toggle phase stays aligned with it.
//  Fetch FSM F_IDLE/F_W1/F_W2:
//   - F_IDLE with uart_rx_ready=1 and parser!=HOLD: toggle uart_rx_read, go to F_W1.
//   - F_W1 -> F_W2 unconditionally.
//   - F_W2: capture uart_rx_byte, pulse byte_stb for 1 cycle, return to F_IDLE.
//   - Pop at cycle N, capture at N+2. uart_rx_ready is ignored in F_W1/F_W2 (it may be stale).
//   - Max throughput: 1 byte per 3 cycles.
//  Parser FSM, advancing on byte_stb:
//   - HUNT: byte==SYNC_BYTE -> LEN; any other byte is dropped silently, no error.
//   - LEN: 0 or >MAX_LEN -> pulse err_len, go to HUNT. Otherwise latch len, sum=LEN, idx=0, go to DATA.
//   - DATA: buf[idx]=byte; sum+=byte (8-bit, mod 256); idx++; after the len-th byte -> CHK.
//     SYNC_BYTE inside the payload is ordinary data (no escaping).
//   - CHK: byte==sum -> frame_len=len, frame_valid=1, frame_count++, go to HOLD.
//     Otherwise pulse err_chk, go to HUNT.
//   - HOLD: no pops; the uart FIFO absorbs incoming bytes. frame_ack -> frame_valid=0 next cycle,
//     go to HUNT. frame_ack outside HOLD is ignored.
//  Buffer: frame_rd_data <= buf[frame_rd_addr] every cycle. Contents are valid only while
//   frame_valid=1 and indices < frame_len. Buffer is not written during HOLD.
//  Timeout (TIMEOUT_CYCLES>0):
//   - Counter clears on every byte_stb and whenever the parser is in HUNT or HOLD.
//   - Counts while in LEN/DATA/CHK. Reaching TIMEOUT_CYCLES -> pulse err_timeout, go to HUNT,
//     discard the partial frame.
//   - If byte_stb and timeout occur in the same cycle, byte_stb wins.
//  Error pulses are mutually exclusive per cycle. frame_len/frame_count hold their values
//   across errors.
//  Async reset mid-frame: partial frame lost, frame_count=0; the next SYNC starts cleanly.
// TESTING
//  Bench: uart (FIFO_DEPTH 64) loopback at clk 50MHz, baud_div 434; DUT fed from uart RX.
//  1 Good frame: send A5 03 11 22 33 69 -> frame_valid=1, frame_len=3,
//     reads addr0..2 = 11 22 33, frame_count=1.
//     After frame_ack: frame_valid=0.
//  2 Bad checksum: send A5 03 11 22 33 00 -> one err_chk pulse, frame_valid stays 0;
//     a following good frame is accepted, frame_count=1.
//  3 Hunt: send 00 FF 5A A5 01 A5 A6 -> no errors, frame_valid=1, len=1,
//     addr0 = A5 (in-payload sync treated as data).
//  4 Length: A5 00 -> err_len; A5 11 -> err_len; A5 10 + 16 bytes 01..10 + correct sum ->
//     frame_len=16, addr15=10.
//  5 Back-pressure: two good frames sent back-to-back, no ack for 20000 cycles -> only the first
//     is held and uart_rx_read stays constant; after frame_ack, the second is delivered intact,
//     frame_count=2.
//  6 Timeout/reset: A5 02 11 then 70000 idle cycles -> one err_timeout; next frame is good.
//     Assert rst_n=0 mid-DATA -> all outputs 0; post-reset frame is good, frame_count=1.

Source files
------------

// File: rtl/uart_frame_rx.sv
// Purpose: pops bytes from the uart RX FIFO and parses SYNC|LEN|PAYLOAD|CHK frames into a readable buffer.
// Latency: byte captured 2 cycles after its pop; frame_valid and err_* register 1 cycle after the last byte; rd_data 1 cycle.
// Backpressure: no pops while a frame is held; the uart FIFO absorbs traffic until frame_ack.
module uart_frame_rx #(
  parameter int          MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       uart_rx_ready,
  input  logic [7:0]                 uart_rx_byte,
  output logic                       uart_rx_read,
  output logic                       frame_valid,
  output logic [7:0]                 frame_len,
  input  logic [$clog2(MAX_LEN)-1:0] frame_rd_addr,
  output logic [7:0]                 frame_rd_data,
  input  logic                       frame_ack,
  output logic                       err_chk,
  output logic                       err_len,
  output logic                       err_timeout,
  output logic [15:0]                frame_count
);

  localparam int          AW   = $clog2(MAX_LEN);
  localparam logic [31:0] TMO  = 32'(TIMEOUT_CYCLES);
  localparam logic [7:0]  MAXL = 8'(MAX_LEN);

  typedef enum logic [1:0] {F_IDLE, F_W1, F_W2} fetch_e;
  typedef enum logic [2:0] {P_HUNT, P_LEN, P_DATA, P_CHK, P_HOLD} parse_e;

  fetch_e         fetch_q, fetch_d;
  parse_e         parse_q, parse_d;
  logic           rd_tgl_q, rd_tgl_d;
  logic [7:0]     len_q, len_d;
  logic [7:0]     sum_q, sum_d;
  logic [7:0]     idx_q, idx_d;
  logic [31:0]    tmo_q, tmo_d;
  logic           frame_valid_q, frame_valid_d;
  logic [7:0]     frame_len_q, frame_len_d;
  logic [15:0]    frame_count_q, frame_count_d;
  logic           err_chk_q, err_chk_d;
  logic           err_len_q, err_len_d;
  logic           err_tmo_q, err_tmo_d;
  logic [7:0]     rd_data_q, rd_data_d;

  logic           byte_stb;
  logic           tmo_hit;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [7:0]     wr_dat;
  logic [7:0]     pay_mem [MAX_LEN];

  // Fetch sequencer: one toggle pops a byte, which is sampled two cycles later once the uart has settled.
  always_comb begin
    fetch_d  = fetch_q;
    rd_tgl_d = rd_tgl_q;
    byte_stb = 1'b0;
    case (fetch_q)
      F_IDLE: begin
        if (uart_rx_ready && (parse_q != P_HOLD)) begin
          rd_tgl_d = ~rd_tgl_q;
          fetch_d  = F_W1;
        end
      end
      F_W1:    fetch_d = F_W2;
      F_W2: begin
        byte_stb = 1'b1;
        fetch_d  = F_IDLE;
      end
      default: fetch_d = F_IDLE;
    endcase
  end

  // Inter-byte timeout fires when the in-frame idle count reaches the limit; a zero limit disables it.
  always_comb begin
    tmo_hit = (TMO != 32'd0) && ((tmo_q + 32'd1) == TMO);
  end

  // Frame parser: a byte strobe always takes priority over a simultaneous timeout.
  always_comb begin
    parse_d       = parse_q;
    len_d         = len_q;
    sum_d         = sum_q;
    idx_d         = idx_q;
    tmo_d         = tmo_q;
    frame_valid_d = frame_valid_q;
    frame_len_d   = frame_len_q;
    frame_count_d = frame_count_q;
    err_chk_d     = 1'b0;
    err_len_d     = 1'b0;
    err_tmo_d     = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = idx_q[AW-1:0];
    wr_dat        = uart_rx_byte;
    case (parse_q)
      P_HUNT: begin
        tmo_d = 32'd0;
        if (byte_stb && (uart_rx_byte == SYNC_BYTE)) begin
          parse_d = P_LEN;
        end
      end
      P_LEN, P_DATA, P_CHK: begin
        if (byte_stb) begin
          tmo_d = 32'd0;
          if (parse_q == P_LEN) begin
            if ((uart_rx_byte == 8'd0) || (uart_rx_byte > MAXL)) begin
              err_len_d = 1'b1;
              parse_d   = P_HUNT;
            end else begin
              len_d   = uart_rx_byte;
              sum_d   = uart_rx_byte;
              idx_d   = 8'd0;
              parse_d = P_DATA;
            end
          end else if (parse_q == P_DATA) begin
            wr_en = 1'b1;
            sum_d = sum_q + uart_rx_byte;
            idx_d = idx_q + 8'd1;
            if ((idx_q + 8'd1) == len_q) begin
              parse_d = P_CHK;
            end
          end else begin
            if (uart_rx_byte == sum_q) begin
              frame_len_d   = len_q;
              frame_valid_d = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
              parse_d       = P_HOLD;
            end else begin
              err_chk_d = 1'b1;
              parse_d   = P_HUNT;
            end
          end
        end else if (tmo_hit) begin
          err_tmo_d = 1'b1;
          tmo_d     = 32'd0;
          parse_d   = P_HUNT;
        end else if (TMO != 32'd0) begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      P_HOLD: begin
        tmo_d = 32'd0;
        if (frame_ack) begin
          frame_valid_d = 1'b0;
          parse_d       = P_HUNT;
        end
      end
      default: parse_d = P_HUNT;
    endcase
  end

  // Registered buffer read port.
  always_comb begin
    rd_data_d = pay_mem[frame_rd_addr];
  end

  // Payload storage; contents are only meaningful while a frame is held, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pay_mem[wr_addr] <= wr_dat;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_q       <= F_IDLE;
      parse_q       <= P_HUNT;
      rd_tgl_q      <= 1'b0;
      len_q         <= 8'd0;
      sum_q         <= 8'd0;
      idx_q         <= 8'd0;
      tmo_q         <= 32'd0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= 8'd0;
      frame_count_q <= 16'd0;
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_tmo_q     <= 1'b0;
      rd_data_q     <= 8'd0;
    end else begin
      fetch_q       <= fetch_d;
      parse_q       <= parse_d;
      rd_tgl_q      <= rd_tgl_d;
      len_q         <= len_d;
      sum_q         <= sum_d;
      idx_q         <= idx_d;
      tmo_q         <= tmo_d;
      frame_valid_q <= frame_valid_d;
      frame_len_q   <= frame_len_d;
      frame_count_q <= frame_count_d;
      err_chk_q     <= err_chk_d;
      err_len_q     <= err_len_d;
      err_tmo_q     <= err_tmo_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign uart_rx_read  = rd_tgl_q;
  assign frame_valid   = frame_valid_q;
  assign frame_len     = frame_len_q;
  assign frame_rd_data = rd_data_q;
  assign frame_count   = frame_count_q;
  assign err_chk       = err_chk_q;
  assign err_len       = err_len_q;
  assign err_timeout   = err_tmo_q;

endmodule
